// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit slice of a ripple adder: sum, carry out of the slice, and the
// carry flowing into the slice's top bit (used for signed overflow detection).
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] wide;

  // Full-width add; the carry into the top bit is recovered from sum ^ a ^ b.
  always_comb begin
    wide = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    sum  = wide[DIGIT-1:0];
    cout = wide[DIGIT];
    cmsb = wide[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock, LSB first.
// Optional build macro ADDSUB_SAT_EN makes the result saturate on signed
// overflow instead of wrapping modulo 2^WIDTH.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  sum_sh;
  logic              carry;
  logic [DIGIT-1:0]  dsum;
  logic              dcout;
  logic              dcmsb;
  logic              accept;
  logic              last_digit;
  logic [WIDTH-1:0]  next_sum;
  logic [WIDTH-1:0]  final_res;
`ifdef ADDSUB_SAT_EN
  logic              a_neg;
`endif

  assign accept     = start && (state == IDLE);
  assign last_digit = (state == RUN) && (count == LAST);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // Digit results enter at the top of the sum register so that after the
  // last digit the full word sits aligned at bit 0.
  always_comb begin
    next_sum  = (sum_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    final_res = next_sum;
`ifdef ADDSUB_SAT_EN
    if (dcmsb ^ dcout) begin
      final_res = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shift registers, inter-digit carry and digit counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
`ifdef ADDSUB_SAT_EN
      a_neg  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= (sub == OP_SUB) ? ~B : B;
      sum_sh <= '0;
      carry  <= sub;
      count  <= '0;
`ifdef ADDSUB_SAT_EN
      a_neg  <= A[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= next_sum;
      carry  <= dcout;
      if (count != LAST) count <= count + CW'(1);
    end
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      Result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (last_digit) begin
      Result    <= final_res;
      carry_out <= dcout;
      overflow  <= dcmsb ^ dcout;
      zero      <= (final_res == '0);
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (default WIDTH=32, DIGIT=4).
// Expectations come from plain integer arithmetic; honours ADDSUB_SAT_EN.
module tb_addsub_serial;

  localparam int W = 32;
  localparam int D = 4;
  localparam int LAT = W / D + 1;

  logic         clock;
  logic         clear;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         done;
  logic [W-1:0] Result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .sub       (sub),
    .A         (A),
    .B         (B),
    .ready     (ready),
    .done      (done),
    .Result    (Result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: integer add/subtract, signed range check, unsigned borrow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic z);
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = s ? (sa - sb) : (sa + sb);
    o  = (sr > 64'sd2147483647) || (sr < -(64'sd2147483648));
    r  = s ? (a - b) : (a + b);
    c  = s ? (a >= b) : ((33'(a) + 33'(b)) > 33'h0FFFFFFFF);
`ifdef ADDSUB_SAT_EN
    if (o) r = a[W-1] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    z  = (r == '0);
  endfunction

  // Called at a falling edge: waits for ready, issues one request, then counts
  // cycles until done (lat = cycle index after the accepting edge).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int lat);
    int guard;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    start = 1'b1;
    A = a;
    B = b;
    sub = s;
    @(negedge clock);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    sub = 1'($urandom);
    lat = 1;
    while (!done && lat < 50) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    clear = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    A = '0;
    B = '0;
    #2 clear = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({ready, done} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL reset_handshake: got ready/done=%b expected 10", {ready, done});
    end
    n_cmp++;
    if ({Result, carry_out, overflow, zero} !== {32'h0, 3'b000}) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %h %b%b%b expected 0 000",
               Result, carry_out, overflow, zero);
    end
    clear = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         ts [4];
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           lat;
    ta = '{32'd5, 32'd3, 32'h7FFFFFFF, 32'h12345678};
    tb = '{32'd3, 32'd5, 32'd1,        32'h12345678};
    ts = '{1'b1,  1'b1,  1'b0,         1'b1};
    for (int i = 0; i < 4; i++) begin
      model(ta[i], tb[i], ts[i], er, ec, eo, ez);
      do_op(ta[i], tb[i], ts[i], lat);
      n_cmp++;
      if (lat !== LAT) begin
        n_bad++;
        $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, LAT);
      end
      n_cmp++;
      if (Result !== er) begin
        n_bad++;
        $display("[TB] FAIL directed%0d_result: got %h expected %h", i, Result, er);
      end
      n_cmp++;
      if ({carry_out, overflow, zero} !== {ec, eo, ez}) begin
        n_bad++;
        $display("[TB] FAIL directed%0d_flags: got c/o/z=%b expected %b",
                 i, {carry_out, overflow, zero}, {ec, eo, ez});
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] corner [5];
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           lat;
    corner = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      s = 1'($urandom);
      model(a, b, s, er, ec, eo, ez);
      do_op(a, b, s, lat);
      n_cmp++;
      if (lat !== LAT) begin
        n_bad++;
        $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, LAT);
      end
      n_cmp++;
      if ({Result, carry_out, overflow, zero} !== {er, ec, eo, ez}) begin
        n_bad++;
        $display("[TB] FAIL random%0d_result: a=%h b=%h sub=%b got %h c/o/z=%b expected %h %b",
                 i, a, b, s, Result, {carry_out, overflow, zero}, er, {ec, eo, ez});
      end
      @(negedge clock);
      n_cmp++;
      if ({ready, done, Result} !== {2'b10, er}) begin
        n_bad++;
        $display("[TB] FAIL random%0d_hold: got ready/done=%b result %h expected 10 %h",
                 i, {ready, done}, Result, er);
      end
    end
  endtask

  task automatic test_start_held;
    logic [W-1:0] a1, b1, a2, b2;
    logic         s1, s2;
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           lat;
    int           guard;
    a1 = W'($urandom); b1 = W'($urandom); s1 = 1'($urandom);
    a2 = W'($urandom); b2 = W'($urandom); s2 = ~s1;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    start = 1'b1;
    A = a1; B = b1; sub = s1;
    lat = 0;
    forever begin
      @(negedge clock);
      lat++;
      if (done || lat >= 50) break;
      A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
    end
    model(a1, b1, s1, er, ec, eo, ez);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("[TB] FAIL held_latency: got %0d expected %0d", lat, LAT);
    end
    n_cmp++;
    if ({Result, carry_out, overflow, zero} !== {er, ec, eo, ez}) begin
      n_bad++;
      $display("[TB] FAIL held_first_operands: got %h expected %h", Result, er);
    end
    A = a2; B = b2; sub = s2;
    @(negedge clock);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL held_ready_after_done: got %b expected 1", ready);
    end
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL held_reaccept: got ready=%b expected 0", ready);
    end
    lat = 1;
    while (!done && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    model(a2, b2, s2, er, ec, eo, ez);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("[TB] FAIL held_second_latency: got %0d expected %0d", lat, LAT);
    end
    n_cmp++;
    if ({Result, carry_out, overflow, zero} !== {er, ec, eo, ez}) begin
      n_bad++;
      $display("[TB] FAIL held_second_result: got %h expected %h", Result, er);
    end
  endtask

  task automatic test_clear_mid_run;
    logic [W-1:0] a, b;
    logic [W-1:0] er;
    logic         ec, eo, ez;
    int           lat;
    int           guard;
    guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    start = 1'b1;
    A = 32'hFFFF0000; B = 32'h00000001; sub = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    #1;
    n_cmp++;
    if ({ready, done} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL clear_handshake: got ready/done=%b expected 10", {ready, done});
    end
    n_cmp++;
    if ({Result, carry_out, overflow, zero} !== {32'h0, 3'b000}) begin
      n_bad++;
      $display("[TB] FAIL clear_outputs: got %h %b expected 0 000",
               Result, {carry_out, overflow, zero});
    end
    @(negedge clock);
    clear = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    model(a, b, 1'b0, er, ec, eo, ez);
    do_op(a, b, 1'b0, lat);
    n_cmp++;
    if (lat !== LAT) begin
      n_bad++;
      $display("[TB] FAIL clear_recover_latency: got %0d expected %0d", lat, LAT);
    end
    n_cmp++;
    if ({Result, carry_out, overflow, zero} !== {er, ec, eo, ez}) begin
      n_bad++;
      $display("[TB] FAIL clear_recover_result: got %h expected %h", Result, er);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_clear_mid_run();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH % DIGIT == 0 is required, otherwise elaboration error.
REQ-003 SHALL have port clock  input  1  single rising-edge clock.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port sub  input  1  mode at acceptance: 0 = A+B, 1 = A-B.
REQ-007 SHALL have port A, B  input  WIDTH  operands, sampled at acceptance only.
REQ-008 SHALL have port ready  output  1  high in IDLE only.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port Result  output  WIDTH  registered result.
REQ-011 SHALL have port carry_out  output  1  final carry (sub: 1 = no borrow).
REQ-012 SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-013 SHALL have port zero  output  1  Result == 0.

Function
REQ-014 SHALL implement FSM IDLE -> RUN on accepted start; RUN -> DONE after WIDTH/DIGIT digit cycles; DONE -> IDLE unconditionally.
REQ-015 SHALL, on acceptance, latch A, B (B inverted when sub=1), and initial carry = sub.
REQ-016 SHALL process DIGIT bits per RUN cycle, LSB digit first, carry registered between digits.
REQ-017 SHALL assert done in DONE exactly WIDTH/DIGIT+1 cycles after the accepting edge (default 9).
REQ-018 SHALL update Result, carry_out, overflow and zero only at the DONE edge; they are held until the next DONE.
REQ-019 SHALL compute overflow = carry into MSB XOR carry out of MSB.
REQ-020 SHALL ignore start while ready=0; no queuing.
REQ-021 SHALL use a digit counter of clog2(WIDTH/DIGIT) bits, clear on acceptance, with no wrap beyond the terminal count.
REQ-022 SHALL support DIGIT == WIDTH, giving one RUN cycle and done 2 cycles after acceptance.

Reset
REQ-023 SHALL, on clear=0, force IDLE, ready=1, done=0, Result=0, carry_out=0, overflow=0, zero=0, counter=0, regardless of clock.
REQ-024 SHALL abort any in-flight operation on reset mid-RUN, with no done pulse and outputs at reset values.
REQ-025 SHALL accept start on the first clock edge after clear deasserts.

Configuration
REQ-026 SHALL, with ADDSUB_SAT_EN defined, saturate Result on overflow: 0x7FF..F if operand A was non-negative, 0x800..0 otherwise; overflow still reports 1.
REQ-027 SHALL, without ADDSUB_SAT_EN, give a wrapped modulo-2^WIDTH Result.

Structure
REQ-028 SHALL take the FSM state enum (IDLE, RUN, DONE) and the mode constants OP_ADD=0 and OP_SUB=1 from shared package addsub_pkg.
REQ-029 SHALL instantiate combinational sub-module addsub_digit (DIGIT-bit slice: a, b, cin -> sum, cout, cmsb) once.

Verification
REQ-030 SHALL check: A=5, B=3, sub=1 -> done at cycle 9, Result=2, carry_out=1, overflow=0, zero=0.
REQ-031 SHALL check: A=3, B=5, sub=1 -> Result=0xFFFFFFFE, carry_out=0, overflow=0.
REQ-032 SHALL check: A=0x7FFFFFFF, B=1, sub=0 -> overflow=1; Result=0x80000000, or 0x7FFFFFFF with ADDSUB_SAT_EN.
REQ-033 SHALL check: A=0x12345678, B=0x12345678, sub=1 -> Result=0, zero=1, carry_out=1.
REQ-034 SHALL check: start held high through RUN with changed A -> only the first operands are used; next acceptance happens the cycle after DONE.
REQ-035 SHALL check: clear pulsed at RUN cycle 4 -> no done, ready=1, Result=0; a new operation then completes normally.
